// File: rtl/cim_accum_writeback.sv
// cim_accum_writeback
//   Consumes output-memory read packets on two lanes, adds the aligned PE
//   partial sums element-wise and returns write-back packets to the output
//   memory's CIM write port. Two register stages: S1 captures the inputs, S2
//   computes the sum and registers the wb_* outputs.
//
//   Recently written values are forwarded, newest first:
//     1. the current wb outputs
//     2. H, the wb outputs from one cycle earlier
//     3. mem_data
//   Forwarding covers the memory write latency window. Two valid S1 packets
//   to the same address are merged into a single lane-1 write.
//
//   Optional build macro CIM_ACCUM_SAT_EN:
//     defined   - each element sum saturates to the signed ELEM_W range
//     undefined - each element sum wraps modulo 2^ELEM_W
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   mem_data/addr/valid_{1,2}_in   read packets, per lane
//   psum_{1,2}_in                  PE partial sums aligned with the read packets
//   clear_in                       first tile: ignore memory/forwarded data
//   wb_data/addr/valid_{1,2}_out   write-back packets, per lane
//   pkt_count_out                  write-back packets issued (wraps)
//   merge_count_out                same-address lane merges (wraps)
module cim_accum_writeback #(
  parameter int DATA_W = 512,
  parameter int ELEM_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_data_1_in,
  input  logic [DATA_W-1:0] mem_data_2_in,
  input  logic [ADDR_W-1:0] mem_addr_1_in,
  input  logic [ADDR_W-1:0] mem_addr_2_in,
  input  logic              mem_valid_1_in,
  input  logic              mem_valid_2_in,
  input  logic [DATA_W-1:0] psum_1_in,
  input  logic [DATA_W-1:0] psum_2_in,
  input  logic              clear_in,
  output logic [DATA_W-1:0] wb_data_1_out,
  output logic [DATA_W-1:0] wb_data_2_out,
  output logic [ADDR_W-1:0] wb_addr_1_out,
  output logic [ADDR_W-1:0] wb_addr_2_out,
  output logic              wb_valid_1_out,
  output logic              wb_valid_2_out,
  output logic [CNT_W-1:0]  pkt_count_out,
  output logic [CNT_W-1:0]  merge_count_out
);

  localparam int NE = DATA_W / ELEM_W;

`ifdef CIM_ACCUM_SAT_EN
  localparam logic signed [ELEM_W+1:0] SMAX = {3'b000, {(ELEM_W-1){1'b1}}};
  localparam logic signed [ELEM_W+1:0] SMIN = {3'b111, {(ELEM_W-1){1'b0}}};
`endif

  // S1 registers
  logic              s1_valid_1, s1_valid_2, s1_clear;
  logic [ADDR_W-1:0] s1_addr_1, s1_addr_2;
  logic [DATA_W-1:0] s1_data_1, s1_data_2, s1_psum_1, s1_psum_2;

  // History of the previous wb cycle
  logic              h_valid_1, h_valid_2;
  logic [ADDR_W-1:0] h_addr_1, h_addr_2;
  logic [DATA_W-1:0] h_data_1, h_data_2;

  logic              merge;
  logic              nv_1, nv_2;
  logic [DATA_W-1:0] base_1, base_2, sum_1, sum_2;

  // Element-wise b + p + q. The three-operand case is evaluated at full
  // precision before any saturation, so it clips only once.
  function automatic logic [DATA_W-1:0] accum(input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] p,
                                               input logic [DATA_W-1:0] q);
    logic [DATA_W-1:0] r;
`ifdef CIM_ACCUM_SAT_EN
    logic signed [ELEM_W+1:0] s;
`endif
    r = '0;
    for (int unsigned i = 0; i < NE; i++) begin
`ifdef CIM_ACCUM_SAT_EN
      s = {{2{b[i*ELEM_W+ELEM_W-1]}}, b[i*ELEM_W +: ELEM_W]}
        + {{2{p[i*ELEM_W+ELEM_W-1]}}, p[i*ELEM_W +: ELEM_W]}
        + {{2{q[i*ELEM_W+ELEM_W-1]}}, q[i*ELEM_W +: ELEM_W]};
      if (s > SMAX)      r[i*ELEM_W +: ELEM_W] = SMAX[ELEM_W-1:0];
      else if (s < SMIN) r[i*ELEM_W +: ELEM_W] = SMIN[ELEM_W-1:0];
      else               r[i*ELEM_W +: ELEM_W] = s[ELEM_W-1:0];
`else
      r[i*ELEM_W +: ELEM_W] = b[i*ELEM_W +: ELEM_W] + p[i*ELEM_W +: ELEM_W]
                            + q[i*ELEM_W +: ELEM_W];
`endif
    end
    return r;
  endfunction

  // Base selection, newest first. Lane 2 wins a tie within one wb cycle;
  // a tie cannot occur in practice because same-address lanes merge.
  function automatic logic [DATA_W-1:0] pick(
      input logic [ADDR_W-1:0] a,   input logic [DATA_W-1:0] mem,
      input logic wv1, input logic [ADDR_W-1:0] wa1, input logic [DATA_W-1:0] wd1,
      input logic wv2, input logic [ADDR_W-1:0] wa2, input logic [DATA_W-1:0] wd2,
      input logic hv1, input logic [ADDR_W-1:0] ha1, input logic [DATA_W-1:0] hd1,
      input logic hv2, input logic [ADDR_W-1:0] ha2, input logic [DATA_W-1:0] hd2);
    if (wv2 && wa2 == a)      return wd2;
    else if (wv1 && wa1 == a) return wd1;
    else if (hv2 && ha2 == a) return hd2;
    else if (hv1 && ha1 == a) return hd1;
    else                      return mem;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_1 <= 1'b0;
      s1_valid_2 <= 1'b0;
      s1_clear   <= 1'b0;
      s1_addr_1  <= '0;
      s1_addr_2  <= '0;
      s1_data_1  <= '0;
      s1_data_2  <= '0;
      s1_psum_1  <= '0;
      s1_psum_2  <= '0;
    end else begin
      s1_valid_1 <= mem_valid_1_in;
      s1_valid_2 <= mem_valid_2_in;
      s1_clear   <= clear_in;
      s1_addr_1  <= mem_addr_1_in;
      s1_addr_2  <= mem_addr_2_in;
      s1_data_1  <= mem_data_1_in;
      s1_data_2  <= mem_data_2_in;
      s1_psum_1  <= psum_1_in;
      s1_psum_2  <= psum_2_in;
    end
  end

  always_comb begin
    merge  = s1_valid_1 && s1_valid_2 && (s1_addr_1 == s1_addr_2);
    nv_1   = s1_valid_1;
    nv_2   = s1_valid_2 && !merge;
    base_1 = pick(s1_addr_1, s1_data_1,
                  wb_valid_1_out, wb_addr_1_out, wb_data_1_out,
                  wb_valid_2_out, wb_addr_2_out, wb_data_2_out,
                  h_valid_1, h_addr_1, h_data_1, h_valid_2, h_addr_2, h_data_2);
    base_2 = pick(s1_addr_2, s1_data_2,
                  wb_valid_1_out, wb_addr_1_out, wb_data_1_out,
                  wb_valid_2_out, wb_addr_2_out, wb_data_2_out,
                  h_valid_1, h_addr_1, h_data_1, h_valid_2, h_addr_2, h_data_2);
    if (s1_clear) begin
      base_1 = '0;
      base_2 = '0;
    end
    sum_1 = accum(base_1, s1_psum_1, merge ? s1_psum_2 : '0);
    sum_2 = accum(base_2, s1_psum_2, '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_1_out  <= 1'b0;
      wb_valid_2_out  <= 1'b0;
      wb_addr_1_out   <= '0;
      wb_addr_2_out   <= '0;
      wb_data_1_out   <= '0;
      wb_data_2_out   <= '0;
      h_valid_1       <= 1'b0;
      h_valid_2       <= 1'b0;
      h_addr_1        <= '0;
      h_addr_2        <= '0;
      h_data_1        <= '0;
      h_data_2        <= '0;
      pkt_count_out   <= '0;
      merge_count_out <= '0;
    end else begin
      wb_valid_1_out <= nv_1;
      wb_valid_2_out <= nv_2;
      if (nv_1) begin
        wb_addr_1_out <= s1_addr_1;
        wb_data_1_out <= sum_1;
      end
      if (nv_2) begin
        wb_addr_2_out <= s1_addr_2;
        wb_data_2_out <= sum_2;
      end
      h_valid_1 <= wb_valid_1_out;
      h_valid_2 <= wb_valid_2_out;
      h_addr_1  <= wb_addr_1_out;
      h_addr_2  <= wb_addr_2_out;
      h_data_1  <= wb_data_1_out;
      h_data_2  <= wb_data_2_out;
      pkt_count_out   <= pkt_count_out + CNT_W'(nv_1) + CNT_W'(nv_2);
      merge_count_out <= merge_count_out + CNT_W'(merge);
    end
  end

endmodule

// File: tb/tb_cim_accum_writeback.sv
// Scoreboard bench for cim_accum_writeback: the driver models the expected
// write-back of each packet and queues it per lane with its due cycle; the
// monitor compares at the falling edge.
module tb_cim_accum_writeback;

  localparam int DW = 512;
  localparam int EW = 32;
  localparam int NE = DW / EW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] mem_data_1 = '0, mem_data_2 = '0, psum_1 = '0, psum_2 = '0;
  logic [7:0]    mem_addr_1 = '0, mem_addr_2 = '0;
  logic          mem_valid_1 = 1'b0, mem_valid_2 = 1'b0, clear = 1'b0;
  logic [DW-1:0] wb_data_1, wb_data_2;
  logic [7:0]    wb_addr_1, wb_addr_2;
  logic          wb_valid_1, wb_valid_2;
  logic [15:0]   pkt_count, merge_count;

  cim_accum_writeback #(.DATA_W(DW), .ELEM_W(EW), .ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_data_1_in(mem_data_1), .mem_data_2_in(mem_data_2),
    .mem_addr_1_in(mem_addr_1), .mem_addr_2_in(mem_addr_2),
    .mem_valid_1_in(mem_valid_1), .mem_valid_2_in(mem_valid_2),
    .psum_1_in(psum_1), .psum_2_in(psum_2), .clear_in(clear),
    .wb_data_1_out(wb_data_1), .wb_data_2_out(wb_data_2),
    .wb_addr_1_out(wb_addr_1), .wb_addr_2_out(wb_addr_2),
    .wb_valid_1_out(wb_valid_1), .wb_valid_2_out(wb_valid_2),
    .pkt_count_out(pkt_count), .merge_count_out(merge_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [7:0]    addr;
    logic [DW-1:0] data;
    bit            merge;
  } exp_t;

  exp_t          q1[$], q2[$];
  int            ecnt = 0;
  int            n_vec = 0, n_miss = 0;
  logic [15:0]   exp_pkt = '0, exp_merge = '0;
  logic [DW-1:0] shadow [256];
  int            last_n [256];
  bit            mon_en = 1'b0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [EW-1:0] e);
    return {NE{e}};
  endfunction

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    for (int i = 0; i < NE; i++) r[i*EW +: EW] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_add(input logic [DW-1:0] b,
                                            input logic [DW-1:0] p,
                                            input logic [DW-1:0] q);
    logic [DW-1:0] r;
    longint        s;
    for (int i = 0; i < NE; i++) begin
      s = longint'($signed(b[i*EW +: EW])) + longint'($signed(p[i*EW +: EW]))
        + longint'($signed(q[i*EW +: EW]));
`ifdef CIM_ACCUM_SAT_EN
      if (s > 64'sd2147483647)       s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      r[i*EW +: EW] = s[31:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_base(input logic [7:0] a,
                                             input logic [DW-1:0] mem,
                                             input bit clr, input int n);
    if (clr) return '0;
    if (last_n[a] >= n - 2) return shadow[a];
    return mem;
  endfunction

  task automatic reset_model();
    q1.delete();
    q2.delete();
    exp_pkt   = '0;
    exp_merge = '0;
    for (int i = 0; i < 256; i++) last_n[i] = -100;
  endtask

  task automatic drive(input bit v1, input logic [7:0] a1, input logic [DW-1:0] m1,
                       input logic [DW-1:0] p1, input bit v2, input logic [7:0] a2,
                       input logic [DW-1:0] m2, input logic [DW-1:0] p2, input bit clr);
    int            n;
    bit            mg;
    logic [DW-1:0] b1, b2, r1, r2;
    exp_t          e;
    n  = ecnt;
    mg = v1 && v2 && (a1 == a2);
    b1 = ref_base(a1, m1, clr, n);
    b2 = ref_base(a2, m2, clr, n);
    r1 = ref_add(b1, p1, mg ? p2 : '0);
    r2 = ref_add(b2, p2, '0);
    if (v1) begin
      e = '{due: n + 2, addr: a1, data: r1, merge: mg};
      q1.push_back(e);
      shadow[a1] = r1;
      last_n[a1] = n;
    end
    if (v2 && !mg) begin
      e = '{due: n + 2, addr: a2, data: r2, merge: 1'b0};
      q2.push_back(e);
      shadow[a2] = r2;
      last_n[a2] = n;
    end
    mem_valid_1 = v1; mem_addr_1 = a1; mem_data_1 = m1; psum_1 = p1;
    mem_valid_2 = v2; mem_addr_2 = a2; mem_data_2 = m2; psum_2 = p2;
    clear = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    mem_valid_1 = 1'b0;
    mem_valid_2 = 1'b0;
    clear       = 1'b0;
    mem_data_1  = rnd512();
    psum_1      = rnd512();
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (q1.size() > 0 && q1[0].due == ecnt) begin
        check_val("wb_valid_1", DW'(wb_valid_1), DW'(1));
        check_val("wb_addr_1", DW'(wb_addr_1), DW'(q1[0].addr));
        check_val("wb_data_1", wb_data_1, q1[0].data);
        exp_pkt = exp_pkt + 16'd1;
        if (q1[0].merge) exp_merge = exp_merge + 16'd1;
        void'(q1.pop_front());
      end else begin
        check_val("wb_valid_1_idle", DW'(wb_valid_1), DW'(0));
      end
      if (q2.size() > 0 && q2[0].due == ecnt) begin
        check_val("wb_valid_2", DW'(wb_valid_2), DW'(1));
        check_val("wb_addr_2", DW'(wb_addr_2), DW'(q2[0].addr));
        check_val("wb_data_2", wb_data_2, q2[0].data);
        exp_pkt = exp_pkt + 16'd1;
        void'(q2.pop_front());
      end else begin
        check_val("wb_valid_2_idle", DW'(wb_valid_2), DW'(0));
      end
      check_val("pkt_count", DW'(pkt_count), DW'(exp_pkt));
      check_val("merge_count", DW'(merge_count), DW'(exp_merge));
    end
  end

  initial begin
    logic [DW-1:0] ma, pa, mb, pb;
    reset_model();
    #2;
    check_val("rst_wb_valid_1", DW'(wb_valid_1), DW'(0));
    check_val("rst_wb_valid_2", DW'(wb_valid_2), DW'(0));
    check_val("rst_wb_data_1", wb_data_1, '0);
    check_val("rst_wb_addr_2", DW'(wb_addr_2), DW'(0));
    check_val("rst_pkt_count", DW'(pkt_count), DW'(0));
    check_val("rst_merge_count", DW'(merge_count), DW'(0));
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // basic path: 10 + 3
    drive(1, 8'h05, fill(10), fill(3), 0, 8'h00, '0, '0, 0);
    idle(4);
    // clear: memory ignored
    drive(1, 8'h07, fill(99), fill(4), 0, 8'h00, '0, '0, 1);
    idle(4);
    // RAW: forwarded from wb, then from H
    drive(1, 8'h10, fill(0), fill(1), 0, 8'h00, '0, '0, 0);
    drive(1, 8'h10, fill(0), fill(2), 0, 8'h00, '0, '0, 0);
    idle(1);
    drive(1, 8'h10, fill(0), fill(5), 0, 8'h00, '0, '0, 0);
    idle(4);
    // RAW across lanes
    drive(1, 8'h11, fill(7), fill(1), 0, 8'h00, '0, '0, 0);
    drive(0, 8'h00, '0, '0, 1, 8'h11, fill(0), fill(6), 0);
    idle(4);
    // lane merge
    drive(1, 8'h20, fill(100), fill(1), 1, 8'h20, fill(100), fill(2), 0);
    idle(4);
    // overflow boundaries on element 0
    ma = '0; pa = '0; mb = '0; pb = '0;
    ma[31:0] = 32'h7FFF_FFFF; pa[31:0] = 32'h0000_0001;
    mb[31:0] = 32'h8000_0000; pb[31:0] = 32'hFFFF_FFFF;
    drive(1, 8'h30, ma, pa, 1, 8'h31, mb, pb, 0);
    idle(4);
    // merged sum clips once at full precision
    drive(1, 8'h32, fill(32'h7FFF_FFF0), fill(32'h10), 1, 8'h32, '0, fill(32'hFFFF_FFE0), 0);
    idle(4);
    // random traffic over a small address set to exercise forwarding/merges
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 3)), rnd512(), rnd512(),
            $urandom_range(0, 3) != 0, 8'($urandom_range(0, 3)), rnd512(), rnd512(),
            $urandom_range(0, 7) == 0);
    end
    idle(4);

    // reset mid-stream with packets in S1 and S2
    drive(1, 8'h40, fill(1), fill(1), 1, 8'h41, fill(2), fill(2), 0);
    drive(1, 8'h42, fill(3), fill(3), 0, 8'h00, '0, '0, 0);
    mem_valid_1 = 1'b0;
    mem_valid_2 = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_val("midrst_wb_valid_1", DW'(wb_valid_1), DW'(0));
    check_val("midrst_wb_valid_2", DW'(wb_valid_2), DW'(0));
    check_val("midrst_pkt_count", DW'(pkt_count), DW'(0));
    check_val("midrst_merge_count", DW'(merge_count), DW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    drive(1, 8'h42, fill(5), fill(1), 0, 8'h00, '0, '0, 0);
    idle(4);

    check_val("drain_q1", DW'(q1.size()), DW'(0));
    check_val("drain_q2", DW'(q2.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cim_accum_writeback.md
Name: cim_accum_writeback

Overview:
- CIM-side consumer of the output-memory read packets and producer of its write-back packets.
- Each lane takes a read packet (data, addr, valid) and the aligned 512-bit PE partial sum, then adds them element-wise.
- The result is returned as a write-back packet (addr, data, valid) to the output memory's CIM write port.
- Two independent lanes, matching the memory's dual-port packet interface, plus read-after-write forwarding and same-address lane merging.

Parameters:
- DATA_W, 512, packet data width.
- ELEM_W, 32, element width; DATA_W/ELEM_W elements per packet, each signed two's complement.
- ADDR_W, 8, packet address width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  block clock, same as the output-memory controller clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_data_1_in, mem_data_2_in  in  DATA_W  data read from the output memory, per lane.
- mem_addr_1_in, mem_addr_2_in  in  ADDR_W  address of each read packet.
- mem_valid_1_in, mem_valid_2_in  in  1  read-packet valid, per lane.
- psum_1_in, psum_2_in  in  DATA_W  PE partial sum aligned with the same-cycle read packet.
- clear_in  in  1  first-tile flag: memory data is ignored and the sum is psum only; sampled with each packet.
- wb_data_1_out, wb_data_2_out  out  DATA_W  write-back data.
- wb_addr_1_out, wb_addr_2_out  out  ADDR_W  write-back address.
- wb_valid_1_out, wb_valid_2_out  out  1  write-back valid, one cycle per packet.
- pkt_count_out  out  CNT_W  write-back packets issued.
- merge_count_out  out  CNT_W  same-address lane merges.

Behaviour:
- Reset:
  - All outputs 0.
  - Both pipeline stages invalid.
  - History register H invalid.
  - Counters 0.
  - Reset mid-operation drops in-flight packets; no write-back is issued for them.
- Pipeline and latency:
  - S1 registers inputs (data, addr, valid, psum, clear) per lane.
  - S2 computes the sum and registers the wb_* outputs.
  - Latency: input at edge t gives wb_valid high after edge t+2.
  - Fully pipelined, one packet per lane per cycle, no backpressure.
- Arithmetic:
  - Per element: result = base + psum, computed modulo 2^ELEM_W.
  - base = 0 when clear is set; otherwise base is the forwarded value.
- Forwarding (base selection for an S1 packet, lane independent, priority order):
  - Current wb output of either lane with the same address and valid; lane 2 is newer than lane 1 only if both match.
  - Else H: the wb packet issued one cycle earlier, same rule.
  - Else mem_data.
  - H holds addr, data and valid of both lanes from the previous wb cycle; it covers the memory write latency window.
- Lane merge:
  - Condition: both S1 lanes valid with equal address.
  - Lane 1 writes base + psum_1 + psum_2.
  - Lane 2 wb_valid is 0.
  - merge_count_out increments by 1.
- Invalid packets: lanes with valid = 0 produce wb_valid = 0, and their data/addr outputs hold their previous values.
- Counters:
  - pkt_count_out adds the number of wb_valid bits asserted each cycle (0, 1 or 2).
  - Both counters wrap at 2^CNT_W.

Optional Feature:
- Macro: CIM_ACCUM_SAT_EN.
- Defined: each element add saturates to the signed range, [-2^(ELEM_W-1), 2^(ELEM_W-1)-1]. The merged three-operand sum saturates once, computed at full precision.
- Undefined: wrap-around modulo 2^ELEM_W.

Test Plan:
- Basic path:
  - Stimulus: lane 1 addr 0x05, mem elements all 10, psum all 3, clear 0.
  - Response: two cycles later wb_addr_1 0x05, all elements 13, wb_valid_1 high for 1 cycle, pkt_count 1.
- Clear:
  - Stimulus: addr 0x07, mem all 99, psum all 4, clear 1.
  - Response: wb data all 4.
- Back-to-back RAW forwarding:
  - Stimulus: addr 0x10 on consecutive cycles, stale mem all 0, psum 1 then 2.
  - Response: writes 1 then 3.
  - Stimulus: a third packet to 0x10 two cycles after the second, psum 5.
  - Response: forwarded from H, writes 8.
- Lane merge:
  - Stimulus: both lanes addr 0x20, mem 100, psum 1 and 2.
  - Response: lane 1 writes 103, wb_valid_2 stays 0, merge_count 1, pkt_count +1.
- Overflow:
  - Stimulus: element 0x7FFFFFFF + 1.
  - Response: wrap gives 0x80000000; with CIM_ACCUM_SAT_EN gives 0x7FFFFFFF. Likewise 0x80000000 + (-1) saturates to 0x80000000.
- Reset mid-stream:
  - Stimulus: assert rst_n low with packets in S1/S2.
  - Response: all wb_valid 0 immediately; counters 0; no write-back after release until new inputs arrive.
